// File: rtl/stage4_pkg.sv
// stage4_pkg: shared types and helpers for the memory-access stage.
package stage4_pkg;
  typedef enum logic [1:0] {MEM_B, MEM_H, MEM_W, MEM_D} mem_size_e;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} lsu_state_e;
  localparam logic [31:0] NAN_BOX_HI = 32'hFFFF_FFFF;
  function automatic logic [7:0] size_strb(mem_size_e s);
    return s == MEM_B ? 8'h01 : s == MEM_H ? 8'h03 : s == MEM_W ? 8'h0F : 8'hFF;
  endfunction
  function automatic logic misaligned(logic [2:0] a, mem_size_e s);
    return s == MEM_H ? a[0] : s == MEM_W ? |a[1:0] : s == MEM_D ? |a : 1'b0;
  endfunction
endpackage

// File: rtl/stage4_load_align.sv
// lsu_load_align: extracts, extends or NaN-boxes the addressed field of a load doubleword.
module lsu_load_align
  import stage4_pkg::*;
(
  input  logic [63:0] rdata_i,
  input  logic [2:0]  offset_i,
  input  mem_size_e   size_i,
  input  logic        uns_i,
  input  logic        reg_type_i,
  output logic [63:0] res_o
);
  logic [63:0] sh;
  assign sh = rdata_i >> {offset_i, 3'b000};
  assign res_o = size_i == MEM_B ? {{56{~uns_i & sh[7]}}, sh[7:0]} :
                 size_i == MEM_H ? {{48{~uns_i & sh[15]}}, sh[15:0]} :
                 size_i == MEM_W ? (reg_type_i ? {NAN_BOX_HI, sh[31:0]} : {{32{~uns_i & sh[31]}}, sh[31:0]}) :
                 sh;
endmodule

// File: rtl/stage4.sv
// stage4: memory-access pipeline stage with a valid/ready data-memory port.
module stage4
  import stage4_pkg::*;
#(
  parameter int ADDR_W = 48,
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_ex,
  input  logic [XLEN-1:0]   op_ex,
  input  logic [XLEN-1:0]   store_data_ex,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ren_ex,
  input  logic              mem_wen_ex,
  input  logic [1:0]        mem_size_ex,
  input  logic              mem_unsigned_ex,
  input  logic [4:0]        rd_ex,
  input  logic              we_rd_ex,
  input  logic              reg_type_ex,
  output logic              stall_mem,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [7:0]        dmem_wstrb,
  input  logic              dmem_rsp_valid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              valid_mem,
  output logic [4:0]        rd_mem,
  output logic [XLEN-1:0]   op_mem,
  output logic              we_rd_mem,
  output logic              reg_type_mem,
  output logic              misalign_mem
);
  lsu_state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  mem_size_e size_q, size_ex;
  logic uns_q, st_q, we_q, rt_q;
  logic [4:0] rd_q, rdm_q, rdm_d;
  logic [XLEN-1:0] wdata_q, wdata_d, st_sh, ld_res, op_q, op_d;
  logic [7:0] wstrb_q, wstrb_d;
  logic valid_q, valid_d, wem_q, wem_d, rtm_q, rtm_d, mis_q, mis_d;
  logic is_mem, bad, start;
  assign size_ex = mem_size_e'(mem_size_ex);
  assign is_mem = mem_ren_ex | mem_wen_ex;
  assign bad = misaligned(mem_addr[2:0], size_ex);
  assign start = state_q == IDLE && valid_ex && is_mem && !bad;
  assign wstrb_d = size_strb(size_ex) << mem_addr[2:0];
  assign st_sh = store_data_ex << {mem_addr[2:0], 3'b000};
  // Lanes outside the strobe are zeroed so stale high bytes never reach the bus.
  for (genvar b = 0; b < 8; b++) begin : g_lane
    assign wdata_d[b*8 +: 8] = wstrb_d[b] ? st_sh[b*8 +: 8] : 8'h00;
  end
  lsu_load_align u_align (
    .rdata_i    (dmem_rdata),
    .offset_i   (addr_q[2:0]),
    .size_i     (size_q),
    .uns_i      (uns_q),
    .reg_type_i (rt_q),
    .res_o      (ld_res)
  );
  always_comb begin
    state_d = state_q;
    valid_d = 1'b0;
    wem_d = 1'b0;
    mis_d = 1'b0;
    op_d = op_q;
    rdm_d = rdm_q;
    rtm_d = rtm_q;
    case (state_q)
      IDLE: if (valid_ex) begin
        if (is_mem && !bad) state_d = REQ;
        else begin
          valid_d = 1'b1;
          mis_d = is_mem;
          op_d = op_ex;
          rdm_d = rd_ex;
          rtm_d = reg_type_ex;
          wem_d = !is_mem && we_rd_ex && (reg_type_ex || rd_ex != 5'd0);
        end
      end
      REQ: if (dmem_req_ready) begin
        state_d = st_q ? IDLE : WAIT;
        valid_d = st_q;
      end
      WAIT: if (dmem_rsp_valid) begin
        state_d = IDLE;
        valid_d = 1'b1;
        op_d = ld_res;
        rdm_d = rd_q;
        rtm_d = rt_q;
        wem_d = we_q && (rt_q || rd_q != 5'd0);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      size_q <= MEM_B;
      {uns_q, st_q, we_q, rt_q} <= '0;
      rd_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      {valid_q, wem_q, rtm_q, mis_q} <= '0;
      op_q <= '0;
      rdm_q <= '0;
    end else begin
      state_q <= state_d;
      {valid_q, wem_q, rtm_q, mis_q} <= {valid_d, wem_d, rtm_d, mis_d};
      op_q <= op_d;
      rdm_q <= rdm_d;
      if (start) begin
        addr_q <= mem_addr;
        size_q <= size_ex;
        uns_q <= mem_unsigned_ex;
        st_q <= mem_wen_ex;
        we_q <= we_rd_ex;
        rt_q <= reg_type_ex;
        rd_q <= rd_ex;
        wdata_q <= wdata_d;
        wstrb_q <= wstrb_d;
      end
    end
  end
  assign stall_mem = state_q != IDLE;
  assign dmem_req_valid = state_q == REQ;
  assign dmem_addr = {addr_q[ADDR_W-1:3], 3'b000};
  assign dmem_we = dmem_req_valid & st_q;
  assign dmem_wdata = wdata_q;
  assign dmem_wstrb = wstrb_q;
  assign valid_mem = valid_q;
  assign rd_mem = rdm_q;
  assign op_mem = op_q;
  assign we_rd_mem = wem_q;
  assign reg_type_mem = rtm_q;
  assign misalign_mem = mis_q;
endmodule

// File: tb/tb_stage4.sv
// tb_stage4: randomized and directed checks of stage4 against a behavioural memory-stage model.
module tb_stage4;
  logic clk = 1'b0, reset;
  logic valid_ex, mem_ren_ex, mem_wen_ex, mem_unsigned_ex, we_rd_ex, reg_type_ex;
  logic [63:0] op_ex, store_data_ex, dmem_rdata, dmem_wdata, op_mem;
  logic [47:0] mem_addr, dmem_addr;
  logic [1:0] mem_size_ex;
  logic [4:0] rd_ex, rd_mem;
  logic stall_mem, dmem_req_valid, dmem_req_ready, dmem_we, dmem_rsp_valid;
  logic valid_mem, we_rd_mem, reg_type_mem, misalign_mem;
  logic [7:0] dmem_wstrb;
  int checks = 0, errors = 0, stall_cycles;
  always #5 clk = ~clk;
  stage4 dut (
    .clk(clk), .reset(reset), .valid_ex(valid_ex), .op_ex(op_ex), .store_data_ex(store_data_ex),
    .mem_addr(mem_addr), .mem_ren_ex(mem_ren_ex), .mem_wen_ex(mem_wen_ex), .mem_size_ex(mem_size_ex),
    .mem_unsigned_ex(mem_unsigned_ex), .rd_ex(rd_ex), .we_rd_ex(we_rd_ex), .reg_type_ex(reg_type_ex),
    .stall_mem(stall_mem), .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata), .valid_mem(valid_mem), .rd_mem(rd_mem),
    .op_mem(op_mem), .we_rd_mem(we_rd_mem), .reg_type_mem(reg_type_mem), .misalign_mem(misalign_mem)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [63:0] ref_load(logic [63:0] d, int off, int sz, bit uns, bit fp);
    int nb = 8 << sz;
    logic [63:0] m = (nb == 64) ? '1 : ((64'd1 << nb) - 64'd1);
    logic [63:0] f = (d >> (off * 8)) & m;
    if (fp && sz == 2) return {32'hFFFF_FFFF, f[31:0]};
    if (!uns && f[nb-1]) f = f | ~m;
    return f;
  endfunction
  task automatic run_op(input bit ren, input bit wen, input int sz, input bit uns, input logic [47:0] addr,
                        input logic [63:0] op, input logic [63:0] sd, input logic [4:0] rd, input bit we,
                        input bit rt, input int rdy_dly, input int rsp_dly, input logic [63:0] rdata);
    bit mem = ren | wen;
    int off = int'(addr[2:0]);
    int nb = 1 << sz;
    bit mis = mem && (off % nb) != 0;
    bit we_exp = we && (rt || rd != 5'd0);
    logic [63:0] ew = '0, bm = '0;
    logic [7:0] es = 8'(((1 << nb) - 1) << off);
    for (int b = 0; b < nb && off + b < 8; b++) begin
      ew[(off+b)*8 +: 8] = sd[b*8 +: 8];
      bm[(off+b)*8 +: 8] = 8'hFF;
    end
    valid_ex = 1'b1; mem_ren_ex = ren; mem_wen_ex = wen; mem_size_ex = 2'(sz); mem_unsigned_ex = uns;
    mem_addr = addr; op_ex = op; store_data_ex = sd; rd_ex = rd; we_rd_ex = we; reg_type_ex = rt;
    chk("idle_stall", stall_mem, 0);
    chk("idle_req", dmem_req_valid, 0);
    step();
    valid_ex = 1'b0;
    stall_cycles = 0;
    if (!mem || mis) begin
      chk("imm_valid", valid_mem, 1);
      chk("imm_misalign", misalign_mem, mis);
      chk("imm_we", we_rd_mem, mis ? 0 : we_exp);
      chk("imm_rd", rd_mem, rd);
      chk("imm_rt", reg_type_mem, rt);
      if (!mis) chk("imm_op", op_mem, op);
      chk("imm_req", dmem_req_valid, 0);
      chk("imm_stall", stall_mem, 0);
      return;
    end
    for (int i = 0; i <= rdy_dly; i++) begin
      chk("req_stall", stall_mem, 1);
      chk("req_valid", dmem_req_valid, 1);
      chk("req_bubble", {valid_mem, we_rd_mem}, 0);
      chk("req_addr", dmem_addr, {addr[47:3], 3'b000});
      chk("req_we", dmem_we, wen);
      if (wen) begin
        chk("req_wstrb", dmem_wstrb, es);
        chk("req_wdata", dmem_wdata & bm, ew);
      end
      stall_cycles++;
      dmem_req_ready = (i == rdy_dly);
      step();
    end
    dmem_req_ready = 1'b0;
    if (wen) begin
      chk("st_valid", valid_mem, 1);
      chk("st_we", we_rd_mem, 0);
      chk("st_misalign", misalign_mem, 0);
      chk("st_stall", stall_mem, 0);
      return;
    end
    for (int i = 0; i <= rsp_dly; i++) begin
      chk("wait_stall", stall_mem, 1);
      chk("wait_req", dmem_req_valid, 0);
      chk("wait_bubble", {valid_mem, we_rd_mem}, 0);
      stall_cycles++;
      dmem_rsp_valid = (i == rsp_dly);
      dmem_rdata = (i == rsp_dly) ? rdata : {$urandom, $urandom};
      step();
    end
    dmem_rsp_valid = 1'b0;
    chk("ld_valid", valid_mem, 1);
    chk("ld_op", op_mem, ref_load(rdata, off, sz, uns, rt));
    chk("ld_we", we_rd_mem, we_exp);
    chk("ld_rd", rd_mem, rd);
    chk("ld_rt", reg_type_mem, rt);
    chk("ld_misalign", misalign_mem, 0);
    chk("ld_stall", stall_mem, 0);
  endtask
  initial begin
    reset = 1'b1;
    {valid_ex, mem_ren_ex, mem_wen_ex, mem_unsigned_ex, we_rd_ex, reg_type_ex} = '0;
    {dmem_req_ready, dmem_rsp_valid} = '0;
    op_ex = '0; store_data_ex = '0; dmem_rdata = '0; mem_addr = '0; mem_size_ex = '0; rd_ex = '0;
    step();
    step();
    chk("rst_outs", {stall_mem, dmem_req_valid, dmem_we, valid_mem, we_rd_mem, reg_type_mem, misalign_mem}, 0);
    chk("rst_op", op_mem, 0);
    chk("rst_addr", dmem_addr, 0);
    reset = 1'b0;
    run_op(0, 0, 3, 0, 48'h0, 64'h1234, 64'h0, 5'd5, 1, 0, 0, 0, 64'h0);
    step();
    chk("pulse_end", valid_mem, 0);
    run_op(1, 0, 0, 0, 48'h1003, 64'h0, 64'h0, 5'd7, 1, 0, 0, 1, 64'h0000_0000_8000_0000);
    chk("lb_op", op_mem, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_stall_cycles", stall_cycles, 3);
    run_op(1, 0, 0, 1, 48'h1003, 64'h0, 64'h0, 5'd7, 1, 0, 0, 1, 64'h0000_0000_8000_0000);
    chk("lbu_op", op_mem, 64'h80);
    run_op(0, 1, 1, 0, 48'h2006, 64'h0, 64'hABCD, 5'd0, 0, 0, 3, 0, 64'h0);
    chk("sh_stall_cycles", stall_cycles, 4);
    run_op(1, 0, 2, 0, 48'h3004, 64'h0, 64'h0, 5'd1, 1, 1, 1, 0, 64'h3F80_0000_1122_3344);
    chk("flw_op", op_mem, 64'hFFFF_FFFF_3F80_0000);
    run_op(1, 0, 3, 0, 48'h4004, 64'h0, 64'h0, 5'd9, 1, 0, 0, 0, 64'h0);
    chk("ld_mis_flag", misalign_mem, 1);
    run_op(0, 0, 0, 0, 48'h0, 64'h55, 64'h0, 5'd0, 1, 0, 0, 0, 64'h0);
    chk("x0_we", we_rd_mem, 0);
    valid_ex = 1'b1; mem_ren_ex = 1'b1; mem_wen_ex = 1'b0; mem_size_ex = 2'd3; mem_addr = 48'h4000;
    step();
    valid_ex = 1'b0; dmem_req_ready = 1'b1;
    step();
    dmem_req_ready = 1'b0;
    chk("wait_before_rst", stall_mem, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_outs", {stall_mem, dmem_req_valid, valid_mem, we_rd_mem, misalign_mem}, 0);
    chk("midrst_op", op_mem, 0);
    dmem_rsp_valid = 1'b1; dmem_rdata = 64'hDEAD_BEEF_0000_0001;
    step();
    dmem_rsp_valid = 1'b0;
    chk("late_rsp_valid", valid_mem, 0);
    chk("late_rsp_stall", stall_mem, 0);
    for (int n = 0; n < 200; n++) begin
      int kind = $urandom_range(0, 2);
      run_op(kind == 1, kind == 2, $urandom_range(0, 3), 1'($urandom), 48'({$urandom, $urandom}),
             {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 2), {$urandom, $urandom});
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
